// File: rtl/cpu_debug_sysclk_bridge.sv
// Moves virtual-JTAG update-DR/update-IR events into the system clock domain through a small command FIFO.
// Optional build macro DEBUG_BRIDGE_OVERRUN_CNT_EN adds a saturating 8-bit dropped-event counter on ovr_cnt.
module cpu_debug_sysclk_bridge #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CMD_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SR_W-1:0]             sr,
  input  logic [IR_W-1:0]             ir_in,
  input  logic                        vs_udr,
  input  logic                        vs_uir,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [IR_W-1:0]             cmd_ir,
  output logic                        cmd_is_uir,
  output logic [SR_W-1:0]             jdo,
  output logic [(2**IR_W)-1:0]        take_action,
  output logic [(2**IR_W)-1:0]        take_no_action,
  output logic [$clog2(CMD_DEPTH):0]  cmd_count,
  output logic                        overrun,
  output logic [7:0]                  ovr_cnt
);

  localparam int AW    = $clog2(CMD_DEPTH);
  localparam int NCMD  = 2 ** IR_W;
  localparam int SUP_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_dly;
  logic                   uir_dly;
  logic [SUP_W-1:0]       sup_cnt;
  logic                   udr_edge;
  logic                   uir_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_dly  <= 1'b0;
      uir_dly  <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      uir_dly  <= uir_sync[SYNC_STAGES-1];
    end
  end

  // Blind window after reset so a level that was already high is not seen as a fresh update.
  always_ff @(posedge clk) begin
    if (reset) begin
      sup_cnt <= SUP_W'(SYNC_STAGES + 1);
    end else if (sup_cnt != '0) begin
      sup_cnt <= sup_cnt - 1'b1;
    end
  end

  assign udr_edge = udr_sync[SYNC_STAGES-1] & ~udr_dly & (sup_cnt == '0);
  assign uir_edge = uir_sync[SYNC_STAGES-1] & ~uir_dly & (sup_cnt == '0);

  logic uir_pend;
  logic uir_pend_nxt;
  logic push_req;
  logic push_uir;

  // Edges cannot repeat on consecutive cycles, so a pending UIR never collides with a new edge.
  always_comb begin
    push_req     = 1'b0;
    push_uir     = 1'b0;
    uir_pend_nxt = uir_pend;
    if (uir_pend) begin
      push_req     = 1'b1;
      push_uir     = 1'b1;
      uir_pend_nxt = 1'b0;
    end else if (udr_edge) begin
      push_req     = 1'b1;
      uir_pend_nxt = uir_edge;
    end else if (uir_edge) begin
      push_req = 1'b1;
      push_uir = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uir_pend <= 1'b0;
    end else begin
      uir_pend <= uir_pend_nxt;
    end
  end

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            pop;
  logic            push_ok;
  logic            drop;
  logic [SR_W-1:0] mem_sr  [CMD_DEPTH];
  logic [IR_W-1:0] mem_ir  [CMD_DEPTH];
  logic            mem_uir [CMD_DEPTH];
  logic [SR_W-1:0] head_sr;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW + 1)'(CMD_DEPTH));
  assign cmd_valid = (count != '0);
  assign cmd_count = count;
  assign pop       = cmd_valid & cmd_ready;
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  assign head_sr    = mem_sr[rd_ptr[AW-1:0]];
  assign cmd_ir     = mem_ir[rd_ptr[AW-1:0]];
  assign cmd_is_uir = mem_uir[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_sr[wr_ptr[AW-1:0]]  <= sr;
      mem_ir[wr_ptr[AW-1:0]]  <= ir_in;
      mem_uir[wr_ptr[AW-1:0]] <= push_uir;
    end
  end

  // Pointers carry one extra bit so full and empty stay distinct across wrap-around.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [NCMD-1:0] head_onehot;

  always_comb begin
    head_onehot         = '0;
    head_onehot[cmd_ir] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      if (pop && !cmd_is_uir) begin
        jdo <= head_sr;
        if (head_sr[SR_W-1]) take_action    <= head_onehot;
        else                 take_no_action <= head_onehot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end
  end

`ifdef DEBUG_BRIDGE_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`else
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_debug_sysclk_bridge.sv
// Directed bench for cpu_debug_sysclk_bridge at default parameters; expected values are hand-computed.
module tb_cpu_debug_sysclk_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] sr_v;
  logic [1:0]  ir_v;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic        cmd_is_uir;
  logic [37:0] jdo;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic [2:0]  cmd_count;
  logic        overrun;
  logic [7:0]  ovr_cnt;

  int vectors     = 0;
  int miscompares = 0;

`ifdef DEBUG_BRIDGE_OVERRUN_CNT_EN
  localparam logic [7:0] OVR_ONE = 8'd1;
`else
  localparam logic [7:0] OVR_ONE = 8'd0;
`endif

  cpu_debug_sysclk_bridge dut (
    .clk            (clk),
    .reset          (reset),
    .sr             (sr_v),
    .ir_in          (ir_v),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_is_uir     (cmd_is_uir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .cmd_count      (cmd_count),
    .overrun        (overrun),
    .ovr_cnt        (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One UDR pulse; ready_at_push raises cmd_ready only on the edge that pushes.
  task automatic pulse_udr(input logic [1:0] ir, input logic [37:0] s, input logic ready_at_push);
    ir_v   = ir;
    sr_v   = s;
    vs_udr = 1'b1;
    tick();
    tick();
    cmd_ready = ready_at_push;
    tick();
    cmd_ready = 1'b0;
    vs_udr    = 1'b0;
    repeat (3) tick();
  endtask

  function automatic logic [37:0] mk_sr(input int j);
    logic [37:0] v;
    v     = 38'h100 + 38'(j);
    v[37] = j[0];
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] oh;
    reset     = 1'b1;
    sr_v      = '0;
    ir_v      = '0;
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_count", 64'(cmd_count), 64'd0);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
    chk("rst_take", 64'({take_action, take_no_action}), 64'd0);
    reset = 1'b0;
    repeat (4) tick();

    // Single UDR with cmd_ready high: valid two edges after sampling, take_action[2] pulse.
    ir_v      = 2'd2;
    sr_v      = 38'h20_0000_1234;
    cmd_ready = 1'b1;
    vs_udr    = 1'b1;
    tick();
    chk("lat_e0_valid", 64'(cmd_valid), 64'd0);
    tick();
    chk("lat_e1_valid", 64'(cmd_valid), 64'd0);
    tick();
    chk("lat_e2_valid", 64'(cmd_valid), 64'd1);
    chk("lat_e2_ir", 64'(cmd_ir), 64'd2);
    chk("lat_e2_uir", 64'(cmd_is_uir), 64'd0);
    chk("lat_e2_count", 64'(cmd_count), 64'd1);
    tick();
    chk("pop1_jdo", 64'(jdo), 64'h20_0000_1234);
    chk("pop1_ta", 64'(take_action), 64'b0100);
    chk("pop1_tna", 64'(take_no_action), 64'd0);
    chk("pop1_valid", 64'(cmd_valid), 64'd0);
    tick();
    chk("pop1_ta_gone", 64'(take_action), 64'd0);
    vs_udr    = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) tick();

    // Five UDR events into a four-entry FIFO: the fifth is dropped.
    for (int j = 0; j < 5; j++) pulse_udr(2'(j), mk_sr(j), 1'b0);
    chk("ovr_count", 64'(cmd_count), 64'd4);
    chk("ovr_flag", 64'(overrun), 64'd1);
    chk("ovr_cnt", 64'(ovr_cnt), 64'(OVR_ONE));
    cmd_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_head_ir", 64'(cmd_ir), 64'(j));
      tick();
      chk("drain_jdo", 64'(jdo), 64'(mk_sr(j)));
      oh = 4'b0001 << j;
      if (j % 2 == 1) begin
        chk("drain_ta", 64'(take_action), 64'(oh));
        chk("drain_tna", 64'(take_no_action), 64'd0);
      end else begin
        chk("drain_ta", 64'(take_action), 64'd0);
        chk("drain_tna", 64'(take_no_action), 64'(oh));
      end
    end
    tick();
    chk("drain_empty_valid", 64'(cmd_valid), 64'd0);
    chk("drain_empty_count", 64'(cmd_count), 64'd0);
    chk("drain_overrun_sticky", 64'(overrun), 64'd1);
    chk("drain_pulse_gone", 64'({take_action, take_no_action}), 64'd0);
    cmd_ready = 1'b0;

    // Simultaneous UDR and UIR: UDR entry first, UIR one cycle later.
    ir_v   = 2'd1;
    sr_v   = 38'h20_0000_0C0C;
    vs_udr = 1'b1;
    vs_uir = 1'b1;
    repeat (3) tick();
    chk("simul_count1", 64'(cmd_count), 64'd1);
    tick();
    chk("simul_count2", 64'(cmd_count), 64'd2);
    vs_udr    = 1'b0;
    vs_uir    = 1'b0;
    cmd_ready = 1'b1;
    chk("simul_head_uir", 64'(cmd_is_uir), 64'd0);
    chk("simul_head_ir", 64'(cmd_ir), 64'd1);
    tick();
    chk("simul_udr_jdo", 64'(jdo), 64'h20_0000_0C0C);
    chk("simul_udr_ta", 64'(take_action), 64'b0010);
    chk("simul_second_uir", 64'(cmd_is_uir), 64'd1);
    chk("simul_second_valid", 64'(cmd_valid), 64'd1);
    tick();
    chk("simul_uir_pulse", 64'({take_action, take_no_action}), 64'd0);
    chk("simul_uir_jdo", 64'(jdo), 64'h20_0000_0C0C);
    chk("simul_uir_valid", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b0;
    repeat (3) tick();

    // vs_udr held high across reset release is not an event.
    vs_udr = 1'b1;
    reset  = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("held_count", 64'(cmd_count), 64'd0);
    chk("held_overrun", 64'(overrun), 64'd0);
    vs_udr = 1'b0;
    repeat (3) tick();
    pulse_udr(2'd3, 38'h00_0000_0D0D, 1'b0);
    chk("held_new_edge_count", 64'(cmd_count), 64'd1);

    // Fill, then a push coinciding with a pop while full.
    pulse_udr(2'd0, 38'h20_0000_0E01, 1'b0);
    pulse_udr(2'd1, 38'h00_0000_0E02, 1'b0);
    pulse_udr(2'd2, 38'h20_0000_0E03, 1'b0);
    chk("full_count", 64'(cmd_count), 64'd4);
    pulse_udr(2'd3, 38'h00_0000_0E04, 1'b1);
    chk("pushpop_count", 64'(cmd_count), 64'd4);
    chk("pushpop_overrun", 64'(overrun), 64'd0);
    chk("pushpop_ovr_cnt", 64'(ovr_cnt), 64'd0);
    chk("pushpop_jdo", 64'(jdo), 64'h00_0000_0D0D);
    chk("pushpop_head_ir", 64'(cmd_ir), 64'd0);

    // Reset with three queued entries flushes everything.
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("pre_rst_count", 64'(cmd_count), 64'd3);
    chk("pre_rst_jdo", 64'(jdo), 64'h20_0000_0E01);
    chk("pre_rst_ta", 64'(take_action), 64'b0001);
    reset = 1'b1;
    tick();
    chk("flush_valid", 64'(cmd_valid), 64'd0);
    chk("flush_count", 64'(cmd_count), 64'd0);
    chk("flush_jdo", 64'(jdo), 64'd0);
    chk("flush_take", 64'({take_action, take_no_action}), 64'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_debug_sysclk_bridge.md
CPU_DEBUG_SYSCLK_BRIDGE -- requirements
Module: cpu_debug_sysclk_bridge

Interface
REQ-001 SHALL have parameter SR_W, default 38, meaning debug scan register width (range 8-64).
REQ-002 SHALL have parameter IR_W, default 2, meaning virtual-JTAG instruction width (range 1-4).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth for vs_udr/vs_uir (range 2-4).
REQ-004 SHALL have parameter CMD_DEPTH, default 4, meaning command FIFO entries (power of 2, range 2-16).
REQ-005 SHALL have port clk  in  1  sole clock; one clock, all logic rising-edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port sr  in  SR_W  scan register from the TCK domain, quasi-static after update.
REQ-008 SHALL have port ir_in  in  IR_W  current virtual IR, quasi-static after update.
REQ-009 SHALL have port vs_udr  in  1  asynchronous update-DR level.
REQ-010 SHALL have port vs_uir  in  1  asynchronous update-IR level.
REQ-011 SHALL have port cmd_valid  out  1  FIFO head valid.
REQ-012 SHALL have port cmd_ready  in  1  consumer accepts head.
REQ-013 SHALL have port cmd_ir  out  IR_W  IR of head entry.
REQ-014 SHALL have port cmd_is_uir  out  1  head entry came from an update-IR event.
REQ-015 SHALL have port jdo  out  SR_W  sr value of the most recently popped entry, held.
REQ-016 SHALL have port take_action  out  2**IR_W  one-hot pulse, index = IR of popped UDR entry with sr[SR_W-1]=1.
REQ-017 SHALL have port take_no_action  out  2**IR_W  one-hot pulse, index = IR of popped UDR entry with sr[SR_W-1]=0.
REQ-018 SHALL have port cmd_count  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.
REQ-019 SHALL have port overrun  out  1  sticky event-dropped flag.
REQ-020 SHALL have port ovr_cnt  out  8  overrun event count (see Configuration).

Function
REQ-021 SHALL pass vs_udr and vs_uir each through SYNC_STAGES flops, then a rising-edge detector (last stage AND NOT delayed copy).
REQ-022 SHALL, on a detected edge, push {ir_in, sr, is_uir} into the FIFO; vs_udr sampled high at clock edge k with an empty FIFO SHALL give cmd_valid=1 after edge k+SYNC_STAGES.
REQ-023 SHALL push at most one entry per cycle; simultaneous UDR and UIR edges push UDR first, with UIR held pending and pushed the next cycle.
REQ-024 SHALL pop on cmd_valid AND cmd_ready; cmd_ir and cmd_is_uir reflect the head combinationally from FIFO storage.
REQ-025 SHALL, on the clock edge that pops an entry, load jdo with its sr and, the following cycle only, pulse exactly one take_action or take_no_action bit if the entry is UDR; UIR pops leave jdo unchanged and pulse nothing.
REQ-026 SHALL, when the FIFO is full and no pop occurs, drop the new event and set overrun; a push with a simultaneous pop when full SHALL succeed without overrun.
REQ-027 SHALL never pop when empty; cmd_ready while empty is ignored.
REQ-028 SHALL keep cmd_count exact across wrap-around of the read/write pointers.

Reset
REQ-029 SHALL, on reset, clear the synchronisers, edge detectors, pending UIR, FIFO pointers, cmd_valid, jdo, take_action, take_no_action, overrun and ovr_cnt to 0, discarding in-flight entries.
REQ-030 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset deasserts so that a level already high is not taken as a new event.

Configuration
REQ-031 SHALL, with DEBUG_BRIDGE_OVERRUN_CNT_EN defined, increment ovr_cnt once per dropped event, saturating at 255, cleared only by reset.
REQ-032 SHALL, without DEBUG_BRIDGE_OVERRUN_CNT_EN, tie ovr_cnt to 0 with no counter logic; overrun behaves identically in both builds.

Verification
REQ-033 SHALL cover: defaults, ir_in=2, sr[37]=1, vs_udr 0->1, cmd_ready=1 -> cmd_valid after 2 edges, jdo=sr, take_action=4'b0100 for one cycle.
REQ-034 SHALL cover: cmd_ready=0, 5 UDR edges, CMD_DEPTH=4 -> cmd_count=4, overrun=1, ovr_cnt=1 (macro on) / 0 (macro off), first 4 entries popped in order.
REQ-035 SHALL cover: vs_udr and vs_uir rising in the same cycle -> UDR entry then UIR entry, cmd_is_uir=0 then 1, no pulse on the UIR pop.
REQ-036 SHALL cover: vs_udr held high through reset release -> no entry pushed; a later 0->1 transition pushes exactly one entry.
REQ-037 SHALL cover: full FIFO, cmd_ready=1 during a new edge -> push accepted, cmd_count stays 4, overrun stays 0.
REQ-038 SHALL cover: reset asserted with 3 queued entries -> next cycle cmd_valid=0, cmd_count=0, jdo=0.
